// File: rtl/input_scan_channel_pkg.sv
// Shared definitions for the input scan path: scan FSM encoding and image
// memory half selection. Also usable by system control.
package input_scan_channel_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_WRITE = 2'd1,
        SCAN_FIN   = 2'd2
    } scan_state_t;

    // The input half of the image memory is selected by address bit 4 = 0.
    localparam logic IMG_IN_HALF = 1'b0;

    // Builds a 5-bit image address in the input half from a bit index.
    function automatic logic [4:0] img_in_addr(input logic [3:0] idx);
        return {IMG_IN_HALF, idx};
    endfunction

endpackage

// File: rtl/input_scan_channel_debounce.sv
// One physical input: two-flop synchroniser followed by a counter debounce.
// STABLE follows the synchronised input only after it has differed from
// STABLE for FILT+1 consecutive samples.
module input_debounce
    import input_scan_channel_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              IN,
    input  logic [FILT_W-1:0] FILT,
    output logic              STABLE
);

    logic              r_sync1;
    logic              r_sync2;
    logic [FILT_W-1:0] r_cnt;
    logic              r_stable;

    // Bring the asynchronous input into the CLK domain.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= IN;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive differing samples; accept the new level at FILT.
    // The counter is cleared on acceptance, so it never exceeds FILT.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == FILT) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign STABLE = r_stable;

endmodule

// File: rtl/input_scan_channel.sv
// Input scan channel: debounces N_IN physical inputs and, on SCAN, writes a
// frozen snapshot of them into the input half of the image memory one bit
// per clock, then pulses DONE.
module input_scan_channel
    import input_scan_channel_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int FILT_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [N_IN-1:0]   IN,
    input  logic [FILT_W-1:0] FILT,
    input  logic              SCAN,
    output logic [4:0]        A,
    output logic              DI,
    output logic              WE,
    output logic              BUSY,
    output logic              DONE,
    output logic [N_IN-1:0]   STABLE
);

    localparam int IDX_W = $clog2(N_IN);

    logic [N_IN-1:0]  w_stable;
    scan_state_t      r_state;
    logic [N_IN-1:0]  r_snap;
    logic [IDX_W-1:0] r_idx;
    logic [4:0]       r_a;
    logic             r_di;
    logic             r_we;
    logic             r_busy;
    logic             r_done;

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        input_debounce #(
            .FILT_W (FILT_W)
        ) u_db (
            .CLK    (CLK),
            .CLR    (CLR),
            .IN     (IN[g]),
            .FILT   (FILT),
            .STABLE (w_stable[g])
        );
    end

    // Scan sequencer with registered memory-port outputs. The image data is
    // taken only from the snapshot so a scan is coherent even while STABLE
    // keeps moving; SCAN outside IDLE is dropped.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= SCAN_IDLE;
            r_snap  <= '0;
            r_idx   <= '0;
            r_a     <= '0;
            r_di    <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                SCAN_IDLE: begin
                    r_we   <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (SCAN) begin
                        r_snap  <= w_stable;
                        r_idx   <= '0;
                        r_state <= SCAN_WRITE;
                    end
                end
                SCAN_WRITE: begin
                    r_we   <= 1'b1;
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    r_a    <= img_in_addr(4'(r_idx));
                    r_di   <= r_snap[r_idx];
                    r_idx  <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(N_IN - 1)) begin
                        r_state <= SCAN_FIN;
                    end
                end
                SCAN_FIN: begin
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= SCAN_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= SCAN_IDLE;
                end
            endcase
        end
    end

    assign A      = r_a;
    assign DI     = r_di;
    assign WE     = r_we;
    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign STABLE = w_stable;

endmodule

// File: tb/tb_input_scan_channel.sv
// Bench for input_scan_channel: directed stimulus, scoreboard of expected
// image writes and DONE pulses checked by an independent monitor.
module tb_input_scan_channel;

    logic        clk;
    logic        clr;
    logic [15:0] in_v;
    logic [3:0]  filt;
    logic        scan;
    logic [4:0]  a;
    logic        di;
    logic        we;
    logic        busy;
    logic        done;
    logic [15:0] stable;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_wr[$];    // {A, DI}
    logic       exp_done[$];

    // 16'hA5C3, bit 0 first
    int scan_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    input_scan_channel dut (
        .CLK    (clk),
        .CLR    (clr),
        .IN     (in_v),
        .FILT   (filt),
        .SCAN   (scan),
        .A      (a),
        .DI     (di),
        .WE     (we),
        .BUSY   (busy),
        .DONE   (done),
        .STABLE (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write / DONE the DUT presents must match the scoreboard.
    initial begin
        logic [5:0] e;
        logic       d;
        forever begin
            @(posedge clk);
            #1;
            if (we) begin
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: A=%0d DI=%0b, none expected at %0t", a, di, $time);
                end else begin
                    e = exp_wr.pop_front();
                    chk("image_write", {26'd0, a, di}, {26'd0, e});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: DONE=1, none expected at %0t", $time);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_pulse", {31'd0, done}, {31'd0, d});
                end
            end
        end
    end

    // Issues SCAN and checks the handshake per edge. abort_at>0 asserts reset
    // just after that edge; coh changes IN and re-requests SCAN mid-scan.
    task automatic run_scan(input int abort_at, input bit coh);
        int n_wr;
        n_wr = (abort_at > 0) ? abort_at : 16;
        for (int i = 0; i < n_wr; i++)
            exp_wr.push_back({1'b0, 4'(i), 1'(scan_bits[i])});
        if (abort_at == 0) exp_done.push_back(1'b1);
        scan = 1'b1;
        tick();              // edge 0
        scan = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("scan_we",   {31'd0, we},   {31'd0, 1'(k <= 16)});
            chk("scan_busy", {31'd0, busy}, {31'd0, 1'(k <= 16)});
            chk("scan_done", {31'd0, done}, {31'd0, 1'(k == 17)});
            if (coh) begin
                if (k == 2) in_v = 16'h0000;
                if (k == 4) scan = 1'b1;
                if (k == 5) scan = 1'b0;
            end
            if (abort_at == k) begin
                #2;
                clr = 1'b0;
                #1;
                chk("abort_ctl", {26'd0, we, busy, done, 3'd0}, 32'd0);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr  = 1'b0;
        in_v = 16'hFFFF;
        filt = 4'd3;
        scan = 1'b0;

        // Reset held with all inputs high
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rst_stable", {16'd0, stable}, 32'd0);
            chk("rst_ctl", {24'd0, we, busy, done, a}, 32'd0);
        end
        in_v = 16'h0000;
        clr  = 1'b1;
        repeat (4) tick();
        chk("idle_stable", {16'd0, stable}, 32'd0);

        // Debounce latency, FILT=3
        in_v = 16'h00FF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("lat_filt3", {16'd0, stable}, (e < 6) ? 32'h0 : 32'h00FF);
        end

        // Debounce latency, FILT=0
        filt = 4'd0;
        in_v = 16'hFF00;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("lat_filt0", {16'd0, stable}, (e < 3) ? 32'h00FF : 32'hFF00);
        end

        filt = 4'd3;
        in_v = 16'h0000;
        repeat (8) tick();
        chk("settle_zero", {16'd0, stable}, 32'd0);

        // 2-clock glitch on IN[5] is rejected
        in_v = 16'h0020;
        tick();
        tick();
        in_v = 16'h0000;
        for (int e = 3; e <= 10; e++) begin
            tick();
            chk("glitch_reject", {16'd0, stable}, 32'd0);
        end

        // 5-clock pulse on IN[5] passes, rise at edge 6, fall at edge 11
        in_v = 16'h0020;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk("pulse_pass", {16'd0, stable}, (e >= 6 && e <= 10) ? 32'h0020 : 32'h0);
            if (e == 5) in_v = 16'h0000;
        end

        // Full scan of 16'hA5C3
        filt = 4'd0;
        in_v = 16'hA5C3;
        repeat (4) tick();
        chk("pre_scan_stable", {16'd0, stable}, 32'h0000A5C3);
        run_scan(0, 1'b0);
        repeat (4) tick();

        // Coherency: IN changes and SCAN repeats during the scan
        run_scan(0, 1'b1);
        repeat (4) tick();
        chk("coh_stable_moved", {16'd0, stable}, 32'd0);

        // Reset in the middle of a scan
        in_v = 16'hA5C3;
        repeat (4) tick();
        chk("pre_abort_stable", {16'd0, stable}, 32'h0000A5C3);
        run_scan(8, 1'b0);
        repeat (3) tick();
        chk("abort_hold", {24'd0, we, busy, done, a}, 32'd0);
        clr = 1'b1;
        repeat (5) tick();
        chk("post_abort_stable", {16'd0, stable}, 32'h0000A5C3);
        run_scan(0, 1'b0);
        repeat (4) tick();

        chk("writes_left", exp_wr.size(), 32'd0);
        chk("done_left", exp_done.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
